// File: rtl/exc_sequencer.sv
// Exception/eret sequencer between M stage, CP0 and the F-stage PC mux; registers IRQ lines,
// redirects and flushes on trap/eret, then masks for a drain window. Optional macro: IRQ_SYNC_EN.
module exc_sequencer #(
  parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  irq_in,
  input  logic        m_valid,
  input  logic [4:0]  m_exc_code,
  input  logic [31:0] m_vpc,
  input  logic        m_bd,
  input  logic        m_is_eret,
  input  logic [31:0] younger_pc,
  input  logic        younger_bd,
  input  logic        cp0_req,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  hw_int,
  output logic [4:0]  exc_code_out,
  output logic [31:0] vpc_out,
  output logic        bd_out,
  output logic        exl_clr,
  output logic        flush_all,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [15:0] trap_count
);

  // The redirect cycle is itself the first flush cycle, so the DRAIN state
  // only covers the remaining EFF_DRAIN-1 cycles.
  localparam int         EFF_DRAIN = (DRAIN_CYCLES < 1) ? 1 : ((DRAIN_CYCLES > 7) ? 7 : DRAIN_CYCLES);
  localparam bit         HAS_DRAIN = (EFF_DRAIN > 1);
  localparam logic [2:0] CNT_LOAD  = 3'((EFF_DRAIN >= 2) ? (EFF_DRAIN - 2) : 0);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [15:0] trap_cnt, trap_cnt_n;
  logic [5:0]  irq_reg;

`ifdef IRQ_SYNC_EN
  logic [5:0] irq_sync1, irq_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_sync1 <= 6'b0;
      irq_sync2 <= 6'b0;
      irq_reg   <= 6'b0;
    end else begin
      irq_sync1 <= irq_in;
      irq_sync2 <= irq_sync1;
      irq_reg   <= irq_sync2;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) irq_reg <= 6'b0;
    else       irq_reg <= irq_in;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      cnt      <= 3'd0;
      trap_cnt <= 16'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      trap_cnt <= trap_cnt_n;
    end
  end

  // Victim info must still name a real PC when M holds a bubble.
  assign vpc_out    = m_valid ? m_vpc : younger_pc;
  assign bd_out     = m_valid ? m_bd  : younger_bd;
  assign busy       = (state == DRAIN);
  assign trap_count = trap_cnt;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    trap_cnt_n   = trap_cnt;
    hw_int       = 6'b0;
    exc_code_out = 5'd0;
    exl_clr      = 1'b0;
    flush_all    = 1'b0;
    pc_redirect  = 1'b0;
    redirect_pc  = 32'h0;
    case (state)
      RUN: begin
        hw_int = irq_reg;
        if (m_valid) exc_code_out = m_exc_code;
        if (cp0_req) begin
          flush_all   = 1'b1;
          pc_redirect = 1'b1;
          redirect_pc = HANDLER_PC;
          if (trap_cnt != 16'hFFFF) trap_cnt_n = trap_cnt + 16'd1;
          if (HAS_DRAIN) begin
            state_n = DRAIN;
            cnt_n   = CNT_LOAD;
          end
        end else if (m_valid && m_is_eret) begin
          exl_clr     = 1'b1;
          flush_all   = 1'b1;
          pc_redirect = 1'b1;
          redirect_pc = cp0_epc;
          if (HAS_DRAIN) begin
            state_n = DRAIN;
            cnt_n   = CNT_LOAD;
          end
        end
      end
      DRAIN: begin
        // Flushed bubbles here must not raise a second trap, so cp0_req is ignored.
        flush_all = 1'b1;
        if (cnt == 3'd0) state_n = RUN;
        else             cnt_n   = cnt - 3'd1;
      end
      default: state_n = RUN;
    endcase
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed table-driven bench for exc_sequencer (default build, DRAIN_CYCLES=2).
module tb_exc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  irq_in;
  logic        m_valid;
  logic [4:0]  m_exc_code;
  logic [31:0] m_vpc;
  logic        m_bd;
  logic        m_is_eret;
  logic [31:0] younger_pc;
  logic        younger_bd;
  logic        cp0_req;
  logic [31:0] cp0_epc;
  logic [5:0]  hw_int;
  logic [4:0]  exc_code_out;
  logic [31:0] vpc_out;
  logic        bd_out;
  logic        exl_clr;
  logic        flush_all;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        busy;
  logic [15:0] trap_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exc_sequencer dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .m_valid(m_valid),
    .m_exc_code(m_exc_code), .m_vpc(m_vpc), .m_bd(m_bd), .m_is_eret(m_is_eret),
    .younger_pc(younger_pc), .younger_bd(younger_bd), .cp0_req(cp0_req),
    .cp0_epc(cp0_epc), .hw_int(hw_int), .exc_code_out(exc_code_out),
    .vpc_out(vpc_out), .bd_out(bd_out), .exl_clr(exl_clr), .flush_all(flush_all),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .busy(busy),
    .trap_count(trap_count)
  );

  typedef struct {
    logic        rst;
    logic [5:0]  irq;
    logic        mv;
    logic [4:0]  exc;
    logic [31:0] vpc;
    logic        bd;
    logic        eret;
    logic [31:0] ypc;
    logic        ybd;
    logic        req;
    logic [31:0] epc;
    logic [5:0]  e_hw;
    logic [4:0]  e_exc;
    logic [31:0] e_vpc;
    logic        e_bd;
    logic        e_exl;
    logic        e_flush;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_busy;
    logic [15:0] e_tc;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst; irq_in = v.irq; m_valid = v.mv; m_exc_code = v.exc;
    m_vpc = v.vpc; m_bd = v.bd; m_is_eret = v.eret; younger_pc = v.ypc;
    younger_bd = v.ybd; cp0_req = v.req; cp0_epc = v.epc;
  endtask

  task automatic compare(input vec_t v, input int i);
    check("hw_int",       i, 32'(hw_int),       32'(v.e_hw));
    check("exc_code_out", i, 32'(exc_code_out), 32'(v.e_exc));
    check("vpc_out",      i, vpc_out,           v.e_vpc);
    check("bd_out",       i, 32'(bd_out),       32'(v.e_bd));
    check("exl_clr",      i, 32'(exl_clr),      32'(v.e_exl));
    check("flush_all",    i, 32'(flush_all),    32'(v.e_flush));
    check("pc_redirect",  i, 32'(pc_redirect),  32'(v.e_redir));
    check("redirect_pc",  i, redirect_pc,       v.e_rpc);
    check("busy",         i, 32'(busy),         32'(v.e_busy));
    check("trap_count",   i, 32'(trap_count),   32'(v.e_tc));
  endtask

  initial begin
    //          rst  irq    mv exc vpc       bd eret ypc      ybd req epc        | hw     exc vpc       bd exl fl rd rpc       busy tc
    vecs[0]  = '{1, 6'h00, 0, 0, 32'h0,    0, 0, 32'h3008, 1, 0, 32'h0,     6'h00, 0, 32'h3008, 1, 0, 0, 0, 32'h0,    0, 0};
    vecs[1]  = '{0, 6'h04, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 32'h0,     6'h00, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 0};
    vecs[2]  = '{0, 6'h00, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 32'h0,     6'h04, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 0};
    vecs[3]  = '{0, 6'h00, 1, 4, 32'h3000, 0, 0, 32'h0,    0, 1, 32'h0,     6'h00, 4, 32'h3000, 0, 0, 1, 1, 32'h4180, 0, 0};
    vecs[4]  = '{0, 6'h3F, 1, 4, 32'h3004, 0, 0, 32'h0,    0, 1, 32'h0,     6'h00, 0, 32'h3004, 0, 0, 1, 0, 32'h0,    1, 1};
    vecs[5]  = '{0, 6'h00, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 32'h0,     6'h3F, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 1};
    vecs[6]  = '{0, 6'h3F, 1, 0, 32'h3020, 0, 1, 32'h0,    0, 0, 32'h3010,  6'h00, 0, 32'h3020, 0, 1, 1, 1, 32'h3010, 0, 1};
    vecs[7]  = '{0, 6'h3F, 0, 0, 32'h0,    0, 0, 32'h3008, 1, 0, 32'h0,     6'h00, 0, 32'h3008, 1, 0, 1, 0, 32'h0,    1, 1};
    vecs[8]  = '{0, 6'h00, 0, 0, 32'h0,    0, 1, 32'h0,    0, 0, 32'h3010,  6'h3F, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 1};
    vecs[9]  = '{0, 6'h00, 1, 0, 32'h3040, 1, 1, 32'h0,    0, 1, 32'h3010,  6'h00, 0, 32'h3040, 1, 0, 1, 1, 32'h4180, 0, 1};
    vecs[10] = '{1, 6'h00, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 32'h0,     6'h00, 0, 32'h0,    0, 0, 1, 0, 32'h0,    1, 2};
    vecs[11] = '{0, 6'h00, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 32'h0,     6'h00, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 0};

    apply(vecs[11]);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      #1 apply(vecs[i]);
      @(negedge clk);
      compare(vecs[i], i);
      @(posedge clk);
    end

    // Saturation: preload the counter one below the ceiling, then trap twice.
    #1 force dut.trap_cnt = 16'hFFFE;
    #1 release dut.trap_cnt;
    m_valid = 1'b1; m_exc_code = 5'd4; m_vpc = 32'h3100; cp0_req = 1'b1;
    @(negedge clk);
    check("sat_redirect", 0, redirect_pc, 32'h0000_4180);
    @(posedge clk);
    #1 cp0_req = 1'b0; m_valid = 1'b0;
    @(negedge clk);
    check("sat_count", 0, 32'(trap_count), 32'h0000_FFFF);
    begin
      int n = 0;
      while (busy && n < 8) begin
        @(posedge clk); #1; n++;
      end
      check("drain_exit", 0, 32'(busy), 32'h0);
    end
    @(posedge clk);
    #1 cp0_req = 1'b1; m_valid = 1'b1;
    @(posedge clk);
    #1 cp0_req = 1'b0; m_valid = 1'b0;
    @(negedge clk);
    check("sat_hold", 0, 32'(trap_count), 32'h0000_FFFF);
    check("sat_busy", 0, 32'(busy), 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("sat_run", 0, 32'(flush_all), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
